// File: rtl/sr_latch_driver.sv
// ============================================================================
// Module   : sr_latch_driver
// Purpose  : Debounces two pushbuttons and issues mutually exclusive,
//            fixed-width active-low set/reset pulses to a NAND RS latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic rst_btn,
    output logic ns,
    output logic nr,
    output logic busy,
    output logic conflict,
    output logic dropped
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_set_p = 2'd1;
    localparam logic [1:0] c_st_rst_p = 2'd2;

    localparam logic [7:0] c_db_last   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] c_pulse_len = 4'(PULSE_CYCLES);

    // bit 0 = set button, bit 1 = reset button
    logic [1:0] w_btn;
    logic [1:0] w_press;

    assign w_btn = {rst_btn, set_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic       r_sync1;
            logic       r_sync2;
            logic       r_db;
            logic       r_db_d;
            logic [7:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    if (r_sync2 == r_db) begin
                        r_cnt <= 8'd0;
                    end else if (r_cnt == c_db_last) begin
                        r_db  <= r_sync2;
                        r_cnt <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            end

            // Only a rising debounced level counts; releases are ignored.
            assign w_press[gi] = r_db & ~r_db_d;
        end
    endgenerate

    logic [1:0] r_state, w_state_nx;
    logic [3:0] r_pcnt,  w_pcnt_nx;
    logic       r_ns, w_ns_nx;
    logic       r_nr, w_nr_nx;
    logic       r_busy, w_busy_nx;
    logic       r_conflict, w_conflict_nx;
    logic       r_dropped, w_dropped_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_pcnt     <= 4'd0;
            r_ns       <= 1'b1;
            r_nr       <= 1'b1;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pcnt     <= w_pcnt_nx;
            r_ns       <= w_ns_nx;
            r_nr       <= w_nr_nx;
            r_busy     <= w_busy_nx;
            r_conflict <= w_conflict_nx;
            r_dropped  <= w_dropped_nx;
        end
    end

    // r_pcnt holds the number of low cycles already committed to the output.
    always_comb begin
        w_state_nx    = r_state;
        w_pcnt_nx     = r_pcnt;
        w_ns_nx       = 1'b1;
        w_nr_nx       = 1'b1;
        w_busy_nx     = 1'b0;
        w_conflict_nx = 1'b0;
        w_dropped_nx  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_pcnt_nx = 4'd0;
                if (w_press[0] && w_press[1]) begin
                    w_conflict_nx = 1'b1;
                end else if (w_press[0]) begin
                    w_state_nx = c_st_set_p;
                    w_pcnt_nx  = 4'd1;
                    w_ns_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end else if (w_press[1]) begin
                    w_state_nx = c_st_rst_p;
                    w_pcnt_nx  = 4'd1;
                    w_nr_nx    = 1'b0;
                    w_busy_nx  = 1'b1;
                end
            end
            c_st_set_p, c_st_rst_p: begin
                w_dropped_nx = |w_press;
                if (r_pcnt == c_pulse_len) begin
                    w_state_nx = c_st_idle;
                    w_pcnt_nx  = 4'd0;
                end else begin
                    w_pcnt_nx = r_pcnt + 4'd1;
                    w_busy_nx = 1'b1;
                    if (r_state == c_st_set_p) w_ns_nx = 1'b0;
                    else                       w_nr_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = c_st_idle;
                w_pcnt_nx  = 4'd0;
            end
        endcase
    end

    assign ns       = r_ns;
    assign nr       = r_nr;
    assign busy     = r_busy;
    assign conflict = r_conflict;
    assign dropped  = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
// ============================================================================
// Module   : tb_sr_latch_driver
// Purpose  : Directed self-checking bench for sr_latch_driver (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_driver;

    logic clk;
    logic rst;
    logic set_btn;
    logic rst_btn;
    logic ns;
    logic nr;
    logic busy;
    logic conflict;
    logic dropped;

    int n_checks = 0;
    int n_errors = 0;

    int m_ns_low, m_nr_low, m_conf, m_drop, m_busy, m_ns_fall;
    int m_both = 0;
    logic prev_ns = 1'b1;

    sr_latch_driver #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .rst_btn (rst_btn),
        .ns      (ns),
        .nr      (nr),
        .busy    (busy),
        .conflict(conflict),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Activity counters sampled mid-cycle.
    always @(negedge clk) begin
        if (!ns)          m_ns_low++;
        if (!nr)          m_nr_low++;
        if (conflict)     m_conf++;
        if (dropped)      m_drop++;
        if (busy)         m_busy++;
        if (!ns && !nr)   m_both++;
        if (prev_ns && !ns) m_ns_fall++;
        prev_ns = ns;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        m_ns_low  = 0;
        m_nr_low  = 0;
        m_conf    = 0;
        m_drop    = 0;
        m_busy    = 0;
        m_ns_fall = 0;
    endtask

    initial begin
        rst     = 1'b1;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        clear_mon();
        tick(3);
        chk("rst_ns", ns, 1);
        chk("rst_nr", nr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_dropped", dropped, 0);
        rst = 1'b0;
        tick(2);

        // Clean set press: ns low after edge 7 for two cycles.
        clear_mon();
        set_btn = 1'b1;
        tick(6);
        chk("set_e6_ns", ns, 1);
        tick();
        chk("set_e7_ns", ns, 0);
        chk("set_e7_busy", busy, 1);
        chk("set_e7_nr", nr, 1);
        tick();
        chk("set_e8_ns", ns, 0);
        chk("set_e8_busy", busy, 1);
        tick();
        chk("set_e9_ns", ns, 1);
        chk("set_e9_busy", busy, 0);
        tick(5);
        chk("set_nr_low", m_nr_low, 0);

        // Release only: no activity at all.
        clear_mon();
        set_btn = 1'b0;
        tick(15);
        chk("rel_ns_low", m_ns_low, 0);
        chk("rel_nr_low", m_nr_low, 0);
        chk("rel_conf", m_conf, 0);
        chk("rel_drop", m_drop, 0);

        // Bounce 1,0,1 then hold: debounce completes at edge 8, ns low after edge 9.
        clear_mon();
        set_btn = 1'b1;
        tick();
        set_btn = 1'b0;
        tick();
        set_btn = 1'b1;
        tick(6);
        chk("bnc_e8_ns", ns, 1);
        tick();
        chk("bnc_e9_ns", ns, 0);
        tick(10);
        chk("bnc_falls", m_ns_fall, 1);
        chk("bnc_ns_low", m_ns_low, 2);
        set_btn = 1'b0;
        tick(12);

        // Clean reset-button press.
        clear_mon();
        rst_btn = 1'b1;
        tick(7);
        chk("rb_e7_nr", nr, 0);
        chk("rb_e7_ns", ns, 1);
        tick(2);
        chk("rb_e9_nr", nr, 1);
        chk("rb_e9_busy", busy, 0);
        rst_btn = 1'b0;
        tick(12);
        chk("rb_nr_low", m_nr_low, 2);

        // Simultaneous presses.
        clear_mon();
        set_btn = 1'b1;
        rst_btn = 1'b1;
        tick(7);
        chk("sim_e7_conflict", conflict, 1);
        tick();
        chk("sim_e8_conflict", conflict, 0);
        tick(12);
        chk("sim_conf_cnt", m_conf, 1);
        chk("sim_ns_low", m_ns_low, 0);
        chk("sim_nr_low", m_nr_low, 0);
        chk("sim_busy", m_busy, 0);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        tick(12);

        // Overlap: reset press lands one cycle into the set pulse.
        clear_mon();
        set_btn = 1'b1;
        tick();
        rst_btn = 1'b1;
        tick(6);
        chk("ovl_e7_ns", ns, 0);
        chk("ovl_e7_dropped", dropped, 0);
        tick();
        chk("ovl_e8_dropped", dropped, 1);
        chk("ovl_e8_nr", nr, 1);
        tick();
        chk("ovl_e9_dropped", dropped, 0);
        chk("ovl_e9_ns", ns, 1);
        tick(10);
        chk("ovl_ns_low", m_ns_low, 2);
        chk("ovl_nr_low", m_nr_low, 0);
        chk("ovl_drop_cnt", m_drop, 1);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        tick(12);

        // Reset mid-pulse, button still held afterwards.
        clear_mon();
        set_btn = 1'b1;
        tick(7);
        chk("rmp_e7_ns", ns, 0);
        rst = 1'b1;
        tick();
        chk("rmp_rst_ns", ns, 1);
        chk("rmp_rst_busy", busy, 0);
        rst = 1'b0;
        tick(6);
        chk("rmp_e6_ns", ns, 1);
        tick();
        chk("rmp_e7b_ns", ns, 0);
        tick(2);
        chk("rmp_e9b_ns", ns, 1);
        set_btn = 1'b0;
        tick(12);

        chk("never_both_low", m_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples needed to accept a button level change (legal range 2..255).
REQ-002 SHALL have parameter PULSE_CYCLES, default 2, meaning the number of cycles an active-low set/reset pulse is held low (legal range 1..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port set_btn, input, 1 bit: raw asynchronous bouncing set pushbutton, active-high.
REQ-007 SHALL have port rst_btn, input, 1 bit: raw asynchronous bouncing reset pushbutton, active-high.
REQ-008 SHALL have port ns, output, 1 bit: registered active-low set drive to the downstream NAND RS latch.
REQ-009 SHALL have port nr, output, 1 bit: registered active-low reset drive to the downstream NAND RS latch.
REQ-010 SHALL have port busy, output, 1 bit: high while a pulse is in progress.
REQ-011 SHALL have port conflict, output, 1 bit: one-cycle strobe for simultaneous accepted presses.
REQ-012 SHALL have port dropped, output, 1 bit: one-cycle strobe for a press discarded because busy.

Function
REQ-013 SHALL pass each button through its own 2-flop synchronizer (sync1, sync2).
REQ-014 SHALL keep one debounced level (db) and one counter per button; each edge where sync2 != db increments the counter, and each edge where sync2 == db clears it.
REQ-015 SHALL load db <= sync2 and clear the counter on the edge where the counter reaches DEBOUNCE_CYCLES (that is, the DEBOUNCE_CYCLES-th consecutive differing sample); a single matching sample (bounce) restarts the count.
REQ-016 SHALL treat only a 0->1 change of db as a press; a 1->0 change (release) SHALL have no effect on ns, nr, or the strobes.
REQ-017 SHALL implement the FSM states IDLE, SET_P, and RST_P; a pulse counter counts cycles in SET_P and RST_P.
REQ-018 In IDLE with a set press only: next state SET_P, ns=0 from that edge, busy=1.
REQ-019 In IDLE with a reset press only: next state RST_P, nr=0 from that edge, busy=1.
REQ-020 In IDLE with both presses in the same cycle: stay IDLE, ns=nr=1, conflict=1 for exactly one cycle.
REQ-021 SHALL hold ns=0 in SET_P and nr=0 in RST_P for exactly PULSE_CYCLES cycles, then drive the output high and return to IDLE with busy=0.
REQ-022 In SET_P or RST_P, any press (either button) SHALL be discarded with dropped=1 for one cycle; it SHALL NOT be queued and SHALL NOT alter the current pulse.
REQ-023 SHALL never drive ns=0 and nr=0 in the same cycle (forbidden latch input), under any input sequence.
REQ-024 SHALL return ns/nr high for at least one cycle between consecutive pulses.
REQ-025 Latency: with stable input, ns (or nr) SHALL fall after the (DEBOUNCE_CYCLES+3)-th rising edge, counting the first edge that samples the raw button high as edge 1.
REQ-026 ns, nr, busy, conflict, and dropped SHALL all be registered outputs with no combinational path from inputs.

Reset
REQ-027 While rst=1 at an edge: ns=1, nr=1, busy=0, conflict=0, dropped=0, FSM=IDLE, all sync flops, db levels, and counters 0.
REQ-028 Reset asserted mid-pulse SHALL force ns/nr high on that same edge, truncating the pulse.
REQ-029 A button held through reset release SHALL be seen as a press once it is debounced after release (db restarts at 0).

Verification
REQ-030 Clean set press, defaults (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2): set_btn 0->1 held -> ns low exactly after edge 7, low for 2 cycles, busy=1 for those cycles, nr stays 1.
REQ-031 Bounce: set_btn toggles 1,0,1 at 1-cycle intervals, then holds -> no pulse until 4 consecutive stable synchronized samples are seen; exactly one ns pulse results.
REQ-032 Simultaneous: both buttons rise on the same edge and are held -> conflict=1 for one cycle, ns and nr never low, FSM stays IDLE.
REQ-033 Overlap: reset press is accepted 1 cycle after a set pulse starts -> dropped=1 for one cycle, nr stays 1, the ns pulse is unchanged at 2 cycles; ns=nr=0 never occurs.
REQ-034 Reset mid-pulse: rst=1 on the second SET_P cycle -> ns=1 and busy=0 on that edge; set_btn still held after rst=0 -> a new ns pulse follows the full debounce latency.
REQ-035 Release only: hold set_btn until its pulse completes, then release -> no ns, nr, conflict, or dropped activity on release.
